icache_refill_axi: RTL and testbench

AXI4 read-burst master that services instruction-cache line refills. Accepts a line request from the icache (`axi_rd_req`/`axi_addr`), issues one 8-beat INCR burst on the AXI AR/R channels, assembles the beats into a 256-bit line buffer, then pulses `axi_gnt` with the full line on `axi_data[0:7]`. It sits between the IF-stage icache and the CPU's AXI bridge/crossbar read port.

---
 rtl/icache_axi_pkg.sv | 23 ++
 rtl/refill_line_buf.sv | 27 ++
 rtl/icache_refill_axi.sv | 159 +++++++++++++++
 tb/tb_icache_refill_axi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_axi_pkg.sv
// icache_axi_pkg: shared state encoding, AXI burst constants and line type
// for the icache line-refill AXI4 read master.
package icache_axi_pkg;

    localparam int         LINE_WORDS = 8;
    localparam logic [3:0] AXI_ID     = 4'd0;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] BURST_LEN  = 8'(LINE_WORDS) - 8'd1;
    localparam logic [2:0] LAST_BEAT  = BURST_LEN[2:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Word i of the line sits at index i (word 0 = first beat).
    typedef logic [0:LINE_WORDS-1][31:0] line_t;

endpackage

// File: rtl/refill_line_buf.sv
// refill_line_buf: 8x32 refill line storage, one indexed write port and a
// full parallel read-out of the assembled line.
module refill_line_buf
    import icache_axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  idx,
    input  logic [31:0] wdata,
    output line_t       line
);

    line_t line_r;

    // Line storage; only the addressed word changes on a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_r <= {LINE_WORDS{32'h0000_0000}};
        end else if (we) begin
            line_r[idx] <= wdata;
        end
    end

    assign line = line_r;

endmodule

// File: rtl/icache_refill_axi.sv
// icache_refill_axi: AXI4 8-beat INCR read master that refills one icache line.
// Optional response checking on refill_err is enabled by ICACHE_REFILL_RESP_CHECK_EN.
module icache_refill_axi
    import icache_axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_rd_req,
    input  logic [31:0] axi_addr,
    output logic        axi_gnt,
    output line_t       axi_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        refill_err
);

    state_e      state_r;
    state_e      state_s;
    logic        accept_s;
    logic        beat_s;
    logic [2:0]  cnt_r;
    logic [31:0] araddr_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        gnt_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus request-accept and beat-write strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        beat_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (axi_rd_req) begin
                    accept_s = 1'b1;
                    state_s  = ST_AR;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_s = ST_R;
                end else begin
                    state_s = ST_AR;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    beat_s = 1'b1;
                    // An early rlast still closes the line; unfilled words keep old data.
                    if ((cnt_r == LAST_BEAT) || rlast) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_R;
                    end
                end else begin
                    state_s = ST_R;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state so they track the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            gnt_r     <= 1'b0;
        end else begin
            arvalid_r <= (state_s == ST_AR);
            rready_r  <= (state_s == ST_R);
            gnt_r     <= (state_s == ST_DONE);
        end
    end

    // Line-aligned burst address capture and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            araddr_r <= 32'h0000_0000;
            cnt_r    <= 3'd0;
        end else if (accept_s) begin
            araddr_r <= {axi_addr[31:5], 5'b0_0000};
            cnt_r    <= 3'd0;
        end else if (beat_s) begin
            cnt_r    <= cnt_r + 3'd1;
        end
    end

    refill_line_buf u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (beat_s),
        .idx   (cnt_r),
        .wdata (rdata),
        .line  (axi_data)
    );

`ifdef ICACHE_REFILL_RESP_CHECK_EN
    logic err_r;
    logic beat_bad_s;
    logic unused_s;

    assign beat_bad_s = (rresp != RESP_OKAY) || (rlast != (cnt_r == LAST_BEAT));

    // Sticky response/framing error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (beat_s && beat_bad_s) begin
            err_r <= 1'b1;
        end
    end

    assign refill_err = err_r;
    assign unused_s   = ^{rid, axi_addr[4:0]};
`else
    logic unused_s;

    assign refill_err = 1'b0;
    assign unused_s   = ^{rid, rresp, axi_addr[4:0]};
`endif

    assign axi_gnt = gnt_r;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;
    assign araddr  = araddr_r;
    assign arid    = AXI_ID;
    assign arlen   = BURST_LEN;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;

endmodule

// File: tb/tb_icache_refill_axi.sv
// tb_icache_refill_axi: randomized refill traffic with a scoreboard of expected
// lines, grant cycles and error flag; a negedge monitor compares DUT outputs.
module tb_icache_refill_axi;
    import icache_axi_pkg::*;

    typedef struct {
        logic [31:0] addr;
        line_t       line;
        logic        err;
        int          gnt_cyc;
        int          ar_cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        axi_rd_req = 1'b0;
    logic [31:0] axi_addr = 32'h0;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'h0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        axi_gnt;
    line_t       axi_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
    logic        refill_err;

    int    cyc = 0;
    int    n_pass = 0;
    int    n_checks = 0;
    exp_t  sb[$];
    line_t model_line = '0;
    logic  model_err = 1'b0;
    int    ar_seen = 0;
    int    hold_left = 0;
    line_t hold_line = '0;
    exp_t  e_mon;

    icache_refill_axi dut (
        .clk(clk), .rst(rst), .axi_rd_req(axi_rd_req), .axi_addr(axi_addr),
        .axi_gnt(axi_gnt), .axi_data(axi_data), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .refill_err(refill_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_arvalid"}, 256'(arvalid), 256'd0);
        chk({tag, "_rready"},  256'(rready),  256'd0);
        chk({tag, "_gnt"},     256'(axi_gnt), 256'd0);
        chk({tag, "_araddr"},  256'(araddr),  256'd0);
        chk({tag, "_arid"},    256'(arid),    256'd0);
        chk({tag, "_arlen"},   256'(arlen),   256'd7);
        chk({tag, "_arsize"},  256'(arsize),  256'd2);
        chk({tag, "_arburst"}, 256'(arburst), 256'd1);
        chk({tag, "_data"},    256'(axi_data), 256'd0);
        chk({tag, "_err"},     256'(refill_err), 256'd0);
    endtask

    // One refill: request, AR after w wait cycles, nbeats beats with stalls.
    // base != 0 gives data base+i, otherwise random data.
    task automatic burst(input logic [31:0] addr, input logic [31:0] base, input int w,
                         input int stall_max, input int stall_beat, input int stall_len,
                         input int nbeats, input int err_beat, input bit drop_req,
                         input bit keep_req);
        int          n;
        int          stalls;
        int          st[8];
        logic [31:0] d[8];
        exp_t        e;
        n = cyc;
        axi_rd_req = 1'b1;
        axi_addr = addr;
        stalls = 0;
        for (int b = 0; b < 8; b++) begin
            d[b] = (base != 32'h0) ? base + 32'(b) : $urandom;
            st[b] = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
            if (b == stall_beat) st[b] = stall_len;
        end
        for (int b = 0; b < nbeats; b++) begin
            model_line[b] = d[b];
            stalls += st[b];
        end
`ifdef ICACHE_REFILL_RESP_CHECK_EN
        if (err_beat >= 0 && err_beat < nbeats) model_err = 1'b1;
        if (nbeats < LINE_WORDS) model_err = 1'b1;
`endif
        e.addr = addr & 32'hFFFF_FFE0;
        e.line = model_line;
        e.err = model_err;
        e.gnt_cyc = n + 2 + w + nbeats + stalls;
        e.ar_cycles = w + 1;
        sb.push_back(e);
        tick();
        if (drop_req) axi_rd_req = 1'b0;
        repeat (w) tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            repeat (st[b]) tick();
            rvalid = 1'b1;
            rdata = d[b];
            rresp = (b == err_beat) ? 2'b10 : 2'b00;
            rlast = (b == nbeats - 1);
            rid = 4'($urandom);
            tick();
            rvalid = 1'b0;
            rlast = 1'b0;
            rresp = 2'b00;
        end
        if (!keep_req) axi_rd_req = 1'b0;
        tick();
    endtask

    // Monitor: AR attributes, rready, grant line/timing/error and post-grant hold.
    always @(negedge clk) begin
        if (!rst) begin
            ar_seen = 0;
            hold_left = 0;
        end else begin
            if (arvalid) begin
                ar_seen++;
                if (sb.size() == 0) begin
                    chk("ar_unexpected", 256'd1, 256'd0);
                end else begin
                    chk("araddr", 256'(araddr), 256'(sb[0].addr));
                    chk("arlen", 256'(arlen), 256'd7);
                    chk("arsize", 256'(arsize), 256'd2);
                    chk("arburst", 256'(arburst), 256'd1);
                    chk("arid", 256'(arid), 256'd0);
                end
            end
            if (rvalid) chk("rready", 256'(rready), 256'd1);
            if (hold_left > 0) begin
                chk("data_hold", 256'(axi_data), 256'(hold_line));
                hold_left--;
            end
            if (axi_gnt) begin
                if (sb.size() == 0) begin
                    chk("gnt_unexpected", 256'd1, 256'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("gnt_cycle", 256'(cyc), 256'(e_mon.gnt_cyc));
                    chk("line", 256'(axi_data), 256'(e_mon.line));
                    chk("refill_err", 256'(refill_err), 256'(e_mon.err));
                    chk("ar_cycles", 256'(ar_seen), 256'(e_mon.ar_cycles));
                    ar_seen = 0;
                    hold_line = e_mon.line;
                    hold_left = 2;
                end
            end
        end
    end

    initial begin
        bit   drop;
        bit   keep;
        exp_t e;
        repeat (3) tick();
        check_reset("por");
        rst = 1'b1;
        repeat (2) tick();

        burst(32'h1FC0_0024, 32'hA0, 0, 0, -1, 0, 8, -1, 1'b0, 1'b0);
        tick();
        burst($urandom, 32'h0, 5, 0, -1, 0, 8, -1, 1'b0, 1'b0);
        tick();
        burst($urandom, 32'h0, 0, 0, 4, 3, 8, -1, 1'b0, 1'b0);
        tick();
        burst($urandom, 32'h0, 1, 1, -1, 0, 8, -1, 1'b1, 1'b0);
        tick();

        for (int i = 0; i < 40; i++) begin
            drop = ($urandom_range(0, 3) == 0);
            keep = !drop && ($urandom_range(0, 3) == 0);
            burst($urandom, 32'h0, int'($urandom_range(0, 3)), 2, -1, 0, 8, -1, drop, keep);
            if (!keep) repeat ($urandom_range(0, 2)) tick();
        end
        axi_rd_req = 1'b0;
        tick();

        burst($urandom, 32'h0, 1, 1, -1, 0, 8, 5, 1'b0, 1'b0);
        burst($urandom, 32'h0, 0, 1, -1, 0, 8, -1, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a burst.
        axi_rd_req = 1'b1;
        axi_addr = 32'h8000_1234;
        e.addr = 32'h8000_1220;
        e.line = model_line;
        e.err = model_err;
        e.gnt_cyc = 0;
        e.ar_cycles = 1;
        sb.push_back(e);
        tick();
        axi_rd_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rdata = $urandom;
            tick();
        end
        rvalid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset("rst_mid");
        sb.delete();
        model_line = '0;
        model_err = 1'b0;
        repeat (2) tick();
        check_reset("rst_hold");
        rst = 1'b1;
        tick();

        burst(32'h0000_0047, 32'h0, 0, 0, -1, 0, 8, -1, 1'b0, 1'b0);
        tick();
        burst(32'h0000_0080, 32'h0, 0, 1, -1, 0, 7, -1, 1'b0, 1'b0);
        repeat (4) tick();

        chk("sb_empty", 256'(sb.size()), 256'd0);
        chk("gnt_idle", 256'(axi_gnt), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
